// File: rtl/prbs_led_status.sv
// Multi-lane PRBS error indicator: per-lane live/sticky/stretch LED FSMs sharing one
// blink generator, plus saturating per-lane error counters.
module prbs_led_lane #(
  parameter int STRETCH = 25_000_000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  input  logic             blink_i,
  input  logic             err_i,
  output logic             led_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);
  localparam int HW = (STRETCH > 1) ? $clog2(STRETCH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_BURST  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_STICKY = 3'd4;

  logic [2:0]       state_q, state_d, exit_st;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;

  // Where FIRST/BURST go once the error strobe drops; mode 3 behaves as live.
  always_comb begin
    case (mode_i)
      2'd1:    exit_st = S_STICKY;
      2'd2:    exit_st = S_HOLD;
      default: exit_st = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE:  if (err_i) state_d = S_FIRST;
      S_FIRST, S_BURST: begin
        if (err_i) state_d = S_BURST;
        else begin
          state_d = exit_st;
          if (exit_st == S_HOLD) hold_d = HW'(STRETCH - 1);
        end
      end
      S_HOLD: begin
        if (err_i)                state_d = S_FIRST;
        else if (mode_i != 2'd2)  state_d = S_IDLE;
        else if (hold_q == '0)    state_d = S_IDLE;
        else                      hold_d  = hold_q - HW'(1);
      end
      S_STICKY: begin
        if (err_i)                state_d = S_BURST;
        else if (mode_i != 2'd1)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign led_d = (state_d == S_BURST) ? blink_i : (state_d != S_IDLE);
  assign cnt_d = (err_i && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign led_o  = led_q;
  assign cnt_o  = cnt_q;
  assign busy_o = (state_q != S_IDLE);
endmodule

module prbs_led_status #(
  parameter int CHANNELS   = 4,
  parameter int BLINK_HALF = 12_500_000,
  parameter int STRETCH    = 25_000_000,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       PRBS_error,
  output logic [CHANNELS-1:0]       led,
  output logic [CHANNELS*CNT_W-1:0] err_count,
  output logic                      any_error
);
  localparam int BW = $clog2(BLINK_HALF);

  logic [BW-1:0]       bcnt_q;
  logic                blink_q;
  logic                any_q;
  logic [CHANNELS-1:0] busy;

  // Shared blink generator; deliberately ignores clear so lanes stay in phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
      bcnt_q  <= '0;
      blink_q <= ~blink_q;
    end else begin
      bcnt_q  <= bcnt_q + BW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    prbs_led_lane #(.STRETCH(STRETCH), .CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .mode_i  (mode),
      .clear_i (clear),
      .blink_i (blink_q),
      .err_i   (PRBS_error[i]),
      .led_o   (led[i]),
      .cnt_o   (err_count[i*CNT_W +: CNT_W]),
      .busy_o  (busy[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) any_q <= 1'b0;
    else        any_q <= |busy;
  end

  assign any_error = any_q;
endmodule

// File: doc/prbs_led_status.md
# prbs_led_status

Multi-channel PRBS error indicator that turns per-lane `PRBS_error` strobes into LED drive. It sits between the PRBS checkers and the board LEDs. It generalises the single-LED display in four ways: a parameterised channel count, an internal shared blink generator, three selectable display modes (live, sticky, stretch), and saturating per-channel error counters for debug readout.

## Interface
Parameters:
- `CHANNELS`, 4: number of PRBS lanes / LEDs.
- `BLINK_HALF`, 12_500_000: blink half-period in `clk` cycles (≥2).
- `STRETCH`, 25_000_000: stretch-mode hold time in cycles (≥1).
- `CNT_W`, 16: width of each error counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  2  0 = live, 1 = sticky, 2 = stretch, 3 = treated as live.
- `clear`  in  1  synchronous pulse; returns all channels to IDLE and zeroes counters.
- `PRBS_error`  in  CHANNELS  per-lane error strobe, sampled every cycle.
- `led`  out  CHANNELS  registered LED drive, active-high.
- `err_count`  out  CHANNELS*CNT_W  saturating error counts; channel i occupies bits [i*CNT_W +: CNT_W].
- `any_error`  out  1  registered; high when any channel is not in IDLE.

## Operation
- **Blink generator.** A single counter runs 0..BLINK_HALF-1 and is shared by all channels.
  - The `blink` register toggles on each wrap.
  - Reset: counter 0, `blink` 0.
  - It is unaffected by `clear`.
- **Per-channel FSM**, with `e` = `PRBS_error[i]`:
  - IDLE (led 0): `e` → FIRST.
  - FIRST (led 1):
    - `e` → BURST.
    - `!e` → next state by mode: live → IDLE; sticky → STICKY; stretch → HOLD, loading `hold_cnt` = STRETCH-1.
  - BURST (led = `blink`):
    - `e` → BURST.
    - `!e` → same mode-dependent exits as FIRST.
  - HOLD (led 1):
    - `e` → FIRST.
    - Mode ≠ stretch → IDLE.
    - `hold_cnt` == 0 → IDLE; otherwise decrement `hold_cnt`.
  - STICKY (led 1):
    - `e` → BURST.
    - Mode ≠ sticky → IDLE.
    - Otherwise stay until `clear`.
- **LED output.** `led[i]` is registered and takes the value belonging to the next state, using the current `blink` register.
- **Error counters.** `err_count[i]` increments on each cycle with `e` = 1 and saturates at 2^CNT_W-1 (no wrap).
- **Priority.** `reset` > `clear` > FSM.
  - `clear` forces every channel to IDLE, all `led` to 0, all counts to 0, and `hold_cnt` to 0.
  - An error arriving in the same cycle as `clear` is dropped and not counted.
- **Mode changes** take effect at the next transition evaluation; no state is lost except as the exits above define.
- **Reset values:** `led` all 0, `err_count` all 0, `any_error` 0, all FSMs IDLE.

## Timing
- `PRBS_error` to `led`: 1 cycle.
- `PRBS_error` to `err_count`: 1 cycle.
- `PRBS_error` to `any_error`: 1 cycle after the state change, i.e. 2 cycles after the strobe.
- In BURST, `led` follows `blink` with 1 cycle of lag.
- Stretch: after the last error cycle, `led` stays 1 for exactly STRETCH cycles of HOLD, then reads 0 on the next cycle.
- Channels are fully independent; simultaneous errors on all lanes are handled in the same cycle.
- `reset` assertion mid-operation clears everything immediately, independent of `clk`. Deassertion should be synchronised externally; the block adds no synchroniser.

## Test plan
All scenarios use CHANNELS=2, BLINK_HALF=4, STRETCH=8, CNT_W=4.
- **Reset:** hold `reset`=0 with `PRBS_error`=2'b11 → `led`=0, counts 0, `any_error`=0; release → normal operation begins.
- **Live mode:** a one-cycle error on ch0 → `led[0]`=1 for 1 cycle, then 0. A 12-cycle error → `led[0]`=1, then follows `blink` (4-cycle half period), then 0 one cycle after the strobe ends; `err_count[0]`=12.
- **Sticky mode:** a single ch1 error → `led[1]` stays 1 indefinitely. A later error makes it blink, then it returns to 1. A `clear` pulse → `led[1]`=0 next cycle and `err_count[1]`=0.
- **Stretch mode:** a one-cycle error on ch0 → `led[0]` high for 1 cycle (FIRST) + 8 cycles (HOLD), then 0. A new error in mid-HOLD restarts the sequence.
- **Saturation / clear priority:** drive ch0 errors for 20 cycles → count holds at 15. Assert `clear` in the same cycle as an error → count 0 and `led` 0.
- **Mode switch:** in STICKY, change `mode` to 0 → IDLE and `led`=0 within 1 cycle. Channel 1 is unaffected throughout.
